// File: rtl/ps2_key_tracker.sv
// PS/2 device-to-host receiver with E0/F0 prefix handling and per-lane key state.
// Frame bits advance on synchronised key_clk falling edges; decoded key state lags the accepted byte by one cycle.
module ps2_key_tracker #(
    parameter int                      NUM_KEYS    = 5,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES   = {8'h5a, 8'h4b, 8'h42, 8'h1b, 8'h1c},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT     = 5'b00000,
    parameter int                      TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_clk,
    input  logic                key_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                frame_err
);

    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]          kclk_sync_q, kclk_sync_d;
    logic [1:0]          kdat_sync_q, kdat_sync_d;
    state_t              state_q, state_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [CW-1:0]       tmo_q, tmo_d;
    logic [7:0]          code_q, code_d;
    logic                code_valid_q, code_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;

    logic fall;
    logic kbit;

    // Stage [0] is the newer sample, [1] the older one.
    assign kclk_sync_d = {kclk_sync_q[0], key_clk};
    assign kdat_sync_d = {kdat_sync_q[0], key_data};
    assign fall        = kclk_sync_q[1] & ~kclk_sync_q[0];
    assign kbit        = kdat_sync_q[1];

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!kbit) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d  = {kbit, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = kbit;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (kbit && ((^shift_q) ^ par_q)) begin
                        code_d       = shift_q;
                        code_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
        end else begin
            tmo_d = tmo_q + CW'(1);
        end
    end

    // Decode runs on the registered byte, so key outputs land one cycle after code_valid.
    always_comb begin
        key_down_d = key_down_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        if (code_valid_q) begin
            if (code_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (code_q == KEY_CODES[8*i +: 8] && ext_q == KEY_EXT[i])
                        key_down_d[i] = ~brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        key_press_d   = key_down_d & ~key_down_q;
        key_release_d = key_down_q & ~key_down_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kclk_sync_q   <= 2'b11;
            kdat_sync_q   <= 2'b11;
            state_q       <= S_IDLE;
            bitcnt_q      <= 3'd0;
            tmo_q         <= '0;
            code_q        <= 8'h00;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_down_q    <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            kclk_sync_q   <= kclk_sync_d;
            kdat_sync_q   <= kdat_sync_d;
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            tmo_q         <= tmo_d;
            code_q        <= code_d;
            code_valid_q  <= code_valid_d;
            frame_err_q   <= frame_err_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    // Shift and parity holding registers carry data only and are always rewritten before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign key_down    = key_down_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign code_valid  = code_valid_q;
    assign code        = code_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected events, a monitor pops them.
module tb_ps2_key_tracker;

    localparam int          NK    = 5;
    localparam int          TMO   = 100;
    localparam int          HALF  = 10;
    localparam logic [39:0] CODES = {8'h5a, 8'h4b, 8'h42, 8'h1b, 8'h1c};
    localparam logic [4:0]  EXT   = 5'b10000;

    localparam int EV_CODE = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_PRS  = 2;
    localparam int EV_REL  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_clk = 1'b1;
    logic          key_data = 1'b1;
    logic [NK-1:0] key_down, key_press, key_release;
    logic          code_valid, frame_err;
    logic [7:0]    code;

    ps2_key_tracker #(
        .NUM_KEYS(NK), .KEY_CODES(CODES), .KEY_EXT(EXT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
        .key_down(key_down), .key_press(key_press), .key_release(key_release),
        .code_valid(code_valid), .code(code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] val;
        logic [4:0] down;
    } ev_t;

    ev_t        evq[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] m_down = 5'b0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [7:0] v, input logic [4:0] d);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.down = d;
        evq.push_back(e);
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [39:0] codes;
        logic [4:0]  ext;
        logic [4:0]  nd;
        codes = CODES;
        ext   = EXT;
        push(EV_CODE, b, m_down);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            nd = m_down;
            for (int i = 0; i < NK; i++)
                if (b == codes[8*i +: 8] && m_ext == ext[i]) nd[i] = ~m_brk;
            if ((nd & ~m_down) != 5'b0) push(EV_PRS, nd & ~m_down, nd);
            if ((m_down & ~nd) != 5'b0) push(EV_REL, m_down & ~nd, nd);
            m_down = nd;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end
    endtask

    task automatic model_err();
        push(EV_ERR, 8'h00, m_down);
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic bit_out(input logic v);
        @(negedge clk);
        key_data = v;
        repeat (HALF) @(negedge clk);
        key_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        key_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit flip);
        logic p;
        p = (~^b) ^ flip;
        if (flip) model_err();
        else model_byte(b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(p);
        bit_out(1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic mon(input int k, input logic [7:0] v);
        ev_t e;
        if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", k, v);
        end else begin
            e = evq.pop_front();
            check("event_kind", k, e.kind);
            if (k != EV_ERR) check("event_val", {24'h0, v}, {24'h0, e.val});
            if (k >= EV_PRS) check("event_down", {27'h0, key_down}, {27'h0, e.down});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (code_valid)   mon(EV_CODE, code);
                if (frame_err)    mon(EV_ERR, 8'h00);
                if (|key_press)   mon(EV_PRS, {3'b0, key_press});
                if (|key_release) mon(EV_REL, {3'b0, key_release});
            end
        end
    end

    initial begin
        int  n;
        bit  seen;
        repeat (3) @(negedge clk);
        check("reset_outputs", {key_down, key_press, key_release, code_valid, code, frame_err}, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single make
        send(8'h1C, 1'b0);
        check("t1_down", key_down, 5'b00001);
        check("t1_code", code, 8'h1C);

        // 2: typematic repeats, then break
        repeat (3) send(8'h1C, 1'b0);
        check("t2_down_held", key_down, 5'b00001);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check("t2_down_released", key_down, 5'b00000);

        // 3: parity error, then good frame
        send(8'h1B, 1'b1);
        check("t3_down_after_err", key_down, 5'b00000);
        check("t3_code_held", code, 8'h1C);
        send(8'h1B, 1'b0);
        check("t3_down", key_down, 5'b00010);

        // 4: extended key
        send(8'hE0, 1'b0);
        send(8'h5A, 1'b0);
        check("t4_ext_make", key_down, 5'b10010);
        send(8'h5A, 1'b0);
        check("t4_bare_5a", key_down, 5'b10010);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h5A, 1'b0);
        check("t4_ext_break", key_down, 5'b00010);
        send(8'hE0, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hF0, 1'b0);
        send(8'hE0, 1'b0);
        send(8'h5A, 1'b0);
        check("t4_f0e0_break", key_down, 5'b00010);

        // 5: partial frame then timeout
        model_err();
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b1);
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= TMO + 40 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_err) begin
                seen = 1'b1;
                n    = k;
            end
        end
        check("t5_timeout_seen", {31'h0, seen}, 32'h1);
        check("t5_timeout_window", {31'h0, (n >= TMO - HALF - 1 && n <= TMO - HALF + 5)}, 32'h1);
        repeat (5) @(negedge clk);
        send(8'h42, 1'b0);
        check("t5_down", key_down, 5'b00110);

        // 6: reset clears pending break prefix
        send(8'h1C, 1'b0);
        send(8'h42, 1'b0);
        check("t6_held", key_down, 5'b00111);
        send(8'hF0, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        m_down = 5'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        #1;
        check("t6_reset_outputs", {key_down, key_press, key_release, code_valid, code, frame_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h1C, 1'b0);
        check("t6_make_after_reset", key_down, 5'b00001);

        repeat (20) @(negedge clk);
        check("queue_empty", evq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
